// File: rtl/game_flow_ctrl.sv
// Pong game sequencer: menu, settings, countdown, play, pause, game-over.
// All timing is counted in refresh_tick frames.
module game_flow_ctrl #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNT_SEC      = 3,
    parameter int OVER_HOLD      = 120,
    parameter int SPEED_MIN      = 1,
    parameter int SPEED_MAX      = 8,
    parameter int SPEED_INIT     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       start_pulse,
    input  logic       setting_pulse,
    input  logic       up_pulse,
    input  logic       down_pulse,
    input  logic       game_over,
    output logic [2:0] game_state,
    output logic       game_active,
    output logic [3:0] ball_speed,
    output logic [2:0] countdown,
    output logic       round_clear,
    output logic       over_ready
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int HW = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

    typedef enum logic [2:0] {
        S_MENU  = 3'd0,
        S_SET   = 3'd1,
        S_CNT   = 3'd2,
        S_PLAY  = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;

    assign game_state  = state;
    assign game_active = (state == S_PLAY);

    // Hold counter saturates at OVER_HOLD rather than wrapping.
    assign hold_nxt = (hold_cnt == HW'(OVER_HOLD)) ? hold_cnt
                                                   : hold_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_MENU;
            ball_speed  <= 4'(SPEED_INIT);
            countdown   <= '0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
            round_clear <= 1'b0;
            over_ready  <= 1'b0;
        end else begin
            round_clear <= 1'b0;
            case (state)
                S_MENU: begin
                    if (start_pulse) begin
                        state       <= S_CNT;
                        countdown   <= 3'(COUNT_SEC);
                        frame_cnt   <= '0;
                        round_clear <= 1'b1;
                    end else if (setting_pulse) begin
                        state <= S_SET;
                    end
                end
                S_SET: begin
                    if (up_pulse && !down_pulse &&
                        ball_speed < 4'(SPEED_MAX))
                        ball_speed <= ball_speed + 4'd1;
                    else if (down_pulse && !up_pulse &&
                             ball_speed > 4'(SPEED_MIN))
                        ball_speed <= ball_speed - 4'd1;
                    if (start_pulse || setting_pulse)
                        state <= S_MENU;
                end
                S_CNT: begin
                    if (setting_pulse) begin
                        state     <= S_MENU;
                        countdown <= '0;
                        frame_cnt <= '0;
                    end else if (refresh_tick) begin
                        if (frame_cnt == FW'(FRAMES_PER_SEC - 1)) begin
                            frame_cnt <= '0;
                            countdown <= countdown - 3'd1;
                            if (countdown == 3'd1)
                                state <= S_PLAY;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (game_over) begin
                        state      <= S_OVER;
                        hold_cnt   <= '0;
                        over_ready <= (OVER_HOLD == 0);
                    end else if (start_pulse) begin
                        state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_pulse)
                        state <= S_PLAY;
                    else if (setting_pulse)
                        state <= S_MENU;
                end
                S_OVER: begin
                    if (start_pulse && over_ready) begin
                        state      <= S_MENU;
                        hold_cnt   <= '0;
                        over_ready <= 1'b0;
                    end else if (refresh_tick) begin
                        hold_cnt   <= hold_nxt;
                        over_ready <= (hold_nxt == HW'(OVER_HOLD));
                    end
                end
                default: begin
                    state      <= S_MENU;
                    countdown  <= '0;
                    frame_cnt  <= '0;
                    hold_cnt   <= '0;
                    over_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scenario bench for game_flow_ctrl with short timing parameters.
// Expected output snapshots are queued with stimulus and popped at sample.
module tb_game_flow_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       act;
        logic [3:0] spd;
        logic [2:0] cd;
        logic       rc;
        logic       rdy;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refresh_tick = 1'b0;
    logic       start_pulse = 1'b0;
    logic       setting_pulse = 1'b0;
    logic       up_pulse = 1'b0;
    logic       down_pulse = 1'b0;
    logic       game_over = 1'b0;
    logic [2:0] game_state;
    logic       game_active;
    logic [3:0] ball_speed;
    logic [2:0] countdown;
    logic       round_clear;
    logic       over_ready;

    int    vectors = 0;
    int    errors  = 0;
    snap_t exp_q[$];
    snap_t e, o;

    game_flow_ctrl #(
        .FRAMES_PER_SEC(4),
        .COUNT_SEC(3),
        .OVER_HOLD(5),
        .SPEED_MIN(1),
        .SPEED_MAX(8),
        .SPEED_INIT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .refresh_tick(refresh_tick),
        .start_pulse(start_pulse),
        .setting_pulse(setting_pulse),
        .up_pulse(up_pulse),
        .down_pulse(down_pulse),
        .game_over(game_over),
        .game_state(game_state),
        .game_active(game_active),
        .ball_speed(ball_speed),
        .countdown(countdown),
        .round_clear(round_clear),
        .over_ready(over_ready)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input int st, input int spd, input int cd,
                                 input bit rc, input bit rdy);
        snap_t s;
        s.st  = 3'(st);
        s.act = (st == 3);
        s.spd = 4'(spd);
        s.cd  = 3'(cd);
        s.rc  = rc;
        s.rdy = rdy;
        return s;
    endfunction

    function automatic snap_t obs();
        return {game_state, game_active, ball_speed, countdown,
                round_clear, over_ready};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d act=%b spd=%0d cd=%0d rc=%b rdy=%b",
                         s.st, s.act, s.spd, s.cd, s.rc, s.rdy);
    endfunction

    // One clock with the given one-cycle pulses; sampled 1ns after the edge.
    task automatic cyc(input bit t, input bit s, input bit se,
                       input bit u, input bit d);
        refresh_tick  = t;
        start_pulse   = s;
        setting_pulse = se;
        up_pulse      = u;
        down_pulse    = d;
        @(posedge clk);
        #1;
        refresh_tick  = 1'b0;
        start_pulse   = 1'b0;
        setting_pulse = 1'b0;
        up_pulse      = 1'b0;
        down_pulse    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        exp_q.push_back(mk(0, 3, 0, 0, 0));
        cyc(0, 1, 0, 0, 0);
        reset = 1'b0;
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_settings();
        int spd;
        exp_q.push_back(mk(1, 3, 0, 0, 0));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL enter_set got %s exp %s", fmt(o), fmt(e));
        end
        spd = 3;
        for (int i = 0; i < 13; i++) begin
            spd = (spd < 8) ? spd + 1 : 8;
            exp_q.push_back(mk(1, spd, 0, 0, 0));
            cyc(0, 0, 0, 1, 0);
            e = exp_q.pop_front(); o = obs();
            if (i == 2 || i >= 11) begin
                vectors++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL speed_up%0d got %s exp %s",
                             i, fmt(o), fmt(e));
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            spd = (spd > 1) ? spd - 1 : 1;
            exp_q.push_back(mk(1, spd, 0, 0, 0));
            cyc(0, 0, 0, 0, 1);
            e = exp_q.pop_front(); o = obs();
            if (i >= 6) begin
                vectors++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL speed_dn%0d got %s exp %s",
                             i, fmt(o), fmt(e));
                end
            end
        end
        exp_q.push_back(mk(1, 1, 0, 0, 0));
        cyc(0, 0, 0, 1, 1);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL up_dn_same got %s exp %s", fmt(o), fmt(e));
        end
        exp_q.push_back(mk(0, 1, 0, 0, 0));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL exit_set got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_countdown();
        exp_q.push_back(mk(2, 1, 3, 1, 0));
        cyc(0, 1, 1, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL start_cnt got %s exp %s", fmt(o), fmt(e));
        end
        exp_q.push_back(mk(2, 1, 3, 0, 0));
        cyc(0, 1, 0, 1, 1);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL clear_1cyc got %s exp %s", fmt(o), fmt(e));
        end
        for (int i = 1; i <= 12; i++) begin
            if (i < 12) exp_q.push_back(mk(2, 1, 3 - i / 4, 0, 0));
            else        exp_q.push_back(mk(3, 1, 0, 0, 0));
            cyc(1, 0, 0, 0, 0);
            e = exp_q.pop_front(); o = obs(); vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL tick%0d got %s exp %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_pause();
        exp_q.push_back(mk(4, 1, 0, 0, 0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL pause got %s exp %s", fmt(o), fmt(e));
        end
        game_over = 1'b1;
        exp_q.push_back(mk(4, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, 0);
        game_over = 1'b0;
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL go_in_pause got %s exp %s", fmt(o), fmt(e));
        end
        exp_q.push_back(mk(3, 1, 0, 0, 0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL resume got %s exp %s", fmt(o), fmt(e));
        end
        game_over = 1'b1;
        exp_q.push_back(mk(5, 1, 0, 0, 0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL over_prio got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_over();
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(mk(5, 1, 0, 0, 0));
            cyc(1, 0, 0, 0, 0);
            e = exp_q.pop_front(); o = obs(); vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL hold%0d got %s exp %s", i, fmt(o), fmt(e));
            end
        end
        exp_q.push_back(mk(5, 1, 0, 0, 0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL early_start got %s exp %s", fmt(o), fmt(e));
        end
        for (int i = 4; i <= 6; i++) begin
            exp_q.push_back(mk(5, 1, 0, 0, i >= 5));
            cyc(1, 0, i == 6, i == 6, 0);
            e = exp_q.pop_front(); o = obs(); vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL hold%0d got %s exp %s", i, fmt(o), fmt(e));
            end
        end
        exp_q.push_back(mk(0, 1, 0, 0, 0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL over_exit got %s exp %s", fmt(o), fmt(e));
        end
        exp_q.push_back(mk(0, 1, 0, 0, 0));
        cyc(1, 0, 0, 0, 0);
        game_over = 1'b0;
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL go_in_menu got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_abort();
        exp_q.push_back(mk(2, 1, 3, 1, 0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_start got %s exp %s", fmt(o), fmt(e));
        end
        for (int i = 1; i <= 7; i++) begin
            exp_q.push_back(mk(2, 1, 3 - i / 4, 0, 0));
            cyc(1, 0, 0, 0, 0);
            e = exp_q.pop_front(); o = obs();
            if (i == 7) begin
                vectors++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL abort_pre got %s exp %s", fmt(o), fmt(e));
                end
            end
        end
        exp_q.push_back(mk(0, 1, 0, 0, 0));
        cyc(1, 0, 1, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort got %s exp %s", fmt(o), fmt(e));
        end
        exp_q.push_back(mk(0, 1, 0, 0, 0));
        cyc(1, 0, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_hold got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_reset_mid_play();
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        exp_q.push_back(mk(0, 7, 0, 0, 0));
        cyc(0, 0, 1, 1, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL exit_with_up got %s exp %s", fmt(o), fmt(e));
        end
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0, 0);
        exp_q.push_back(mk(3, 7, 0, 0, 0));
        cyc(1, 0, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL play7 got %s exp %s", fmt(o), fmt(e));
        end
        reset = 1'b1;
        exp_q.push_back(mk(0, 3, 0, 0, 0));
        cyc(0, 1, 0, 0, 0);
        reset = 1'b0;
        e = exp_q.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_play got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_settings();
        test_countdown();
        test_pause();
        test_over();
        test_abort();
        test_reset_mid_play();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
